// File: rtl/rgb2ycbcr_pkg.sv
// rgb2ycbcr_pkg: shared definitions for the streaming RGB->YCbCr converter.
// Holds the mode encoding, the real-valued coefficient table (8-bit scale),
// offset and clamp constants, and elaboration-time helpers that produce
// fixed-point coefficients and bit-depth-scaled constants.
// Channel index convention: 0 = Y, 1 = Cb, 2 = Cr; term index 0/1/2 = R/G/B.
package rgb2ycbcr_pkg;

  typedef enum logic {
    MODE_JFIF   = 1'b0,
    MODE_STUDIO = 1'b1
  } mode_e;

  // Real-valued conversion matrix, one entry per (mode, channel, term).
  function automatic real coef_real(input mode_e mode, input int ch, input int k);
    real c;
    c = 0.0;
    if (mode == MODE_JFIF) begin
      case (ch * 3 + k)
        0: c = 0.299;
        1: c = 0.587;
        2: c = 0.114;
        3: c = -0.168736;
        4: c = -0.331264;
        5: c = 0.5;
        6: c = 0.5;
        7: c = -0.418688;
        8: c = -0.081312;
        default: c = 0.0;
      endcase
    end else begin
      case (ch * 3 + k)
        0: c = 65.481 / 255.0;
        1: c = 128.553 / 255.0;
        2: c = 24.966 / 255.0;
        3: c = -37.797 / 255.0;
        4: c = -74.203 / 255.0;
        5: c = 112.0 / 255.0;
        6: c = 112.0 / 255.0;
        7: c = -93.786 / 255.0;
        8: c = -18.214 / 255.0;
        default: c = 0.0;
      endcase
    end
    return c;
  endfunction

  // Round half away from zero.
  function automatic int round_real(input real x);
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end else begin
      return -$rtoi(0.5 - x);
    end
  endfunction

  // Coefficient as round(real * 2^frac_w).
  function automatic int coef_scaled(input mode_e mode, input int ch, input int k,
                                     input int frac_w);
    real s;
    s = 1.0;
    for (int i = 0; i < frac_w; i++) begin
      s = s * 2.0;
    end
    return round_real(coef_real(mode, ch, k) * s);
  endfunction

  // Scale an 8-bit-domain constant to pix_w bits.
  function automatic int scale8(input int v, input int pix_w);
    return v << (pix_w - 8);
  endfunction

  function automatic int offset_scaled(input mode_e mode, input int ch, input int pix_w);
    if (ch != 0) begin
      return scale8(128, pix_w);
    end else if (mode == MODE_STUDIO) begin
      return scale8(16, pix_w);
    end else begin
      return 0;
    end
  endfunction

  function automatic int clamp_lo(input mode_e mode, input int pix_w);
    if (mode == MODE_STUDIO) begin
      return scale8(16, pix_w);
    end else begin
      return 0;
    end
  endfunction

  function automatic int clamp_hi(input mode_e mode, input int ch, input int pix_w);
    if (mode == MODE_JFIF) begin
      return (1 << pix_w) - 1;
    end else if (ch == 0) begin
      return scale8(235, pix_w);
    end else begin
      return scale8(240, pix_w);
    end
  endfunction

endpackage

// File: rtl/rgb2ycbcr_mac.sv
// rgb2ycbcr_mac: one output channel of the converter, three registered stages.
//   S1: three products of unsigned pixel components and signed coefficients.
//   S2: sum of products plus (offset << FRAC_W) plus the rounding constant.
//   S3: arithmetic shift down by FRAC_W and clamp to [lo, hi].
// Ports: clk/rst; en1..en3 per-stage load enables from the top-level control;
// r/g/b pixel; c0..c2 coefficients (sampled with the pixel); off (used in S2);
// lo/hi clamp bounds (used in S3); result = registered channel output.
module rgb2ycbcr_mac #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en1,
  input  logic                     en2,
  input  logic                     en3,
  input  logic [PIX_W-1:0]         r,
  input  logic [PIX_W-1:0]         g,
  input  logic [PIX_W-1:0]         b,
  input  logic signed [FRAC_W+1:0] c0,
  input  logic signed [FRAC_W+1:0] c1,
  input  logic signed [FRAC_W+1:0] c2,
  input  logic [PIX_W-1:0]         off,
  input  logic [PIX_W-1:0]         lo,
  input  logic [PIX_W-1:0]         hi,
  output logic [PIX_W-1:0]         result
);
  localparam int CW    = FRAC_W + 2;
  localparam int ACC_W = PIX_W + FRAC_W + 3;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2 ** (FRAC_W - 1));

  function automatic logic signed [ACC_W-1:0] ext_pix(input logic [PIX_W-1:0] p);
    return $signed({{(ACC_W - PIX_W){1'b0}}, p});
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_coef(input logic signed [CW-1:0] c);
    return $signed({{(ACC_W - CW){c[CW-1]}}, c});
  endfunction

  logic signed [ACC_W-1:0] p0, p1, p2, acc, shifted;
  logic [PIX_W-1:0]        clamped;

  // Shift and clamp the accumulated sum for stage 3.
  always_comb begin
    shifted = acc >>> FRAC_W;
    if (shifted < ext_pix(lo)) begin
      clamped = lo;
    end else if (shifted > ext_pix(hi)) begin
      clamped = hi;
    end else begin
      clamped = shifted[PIX_W-1:0];
    end
  end

  // Three datapath stages; operands are sized so nothing truncates.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0     <= '0;
      p1     <= '0;
      p2     <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (en1) begin
        p0 <= ext_pix(r) * ext_coef(c0);
        p1 <= ext_pix(g) * ext_coef(c1);
        p2 <= ext_pix(b) * ext_coef(c2);
      end
      if (en2) begin
        acc <= p0 + p1 + p2 + (ext_pix(off) <<< FRAC_W) + ROUND;
      end
      if (en3) begin
        result <= clamped;
      end
    end
  end

endmodule

// File: rtl/rgb2ycbcr_stream.sv
// rgb2ycbcr_stream: pipelined RGB->YCbCr converter on a valid/ready stream.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_r/in_g/
// in_b/in_user input stream; out_valid/out_ready/out_y/out_cb/out_cr/out_user
// output stream; busy = any stage holds a pixel.
// Three bubble-collapsing stages: a stage loads when it is empty or the stage
// after it loads. Mode and user bits ride alongside the pixel so that every
// pixel uses its own coefficients, offset and clamp range.
module rgb2ycbcr_stream
  import rgb2ycbcr_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [PIX_W-1:0]  in_r,
  input  logic [PIX_W-1:0]  in_g,
  input  logic [PIX_W-1:0]  in_b,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_y,
  output logic [PIX_W-1:0]  out_cb,
  output logic [PIX_W-1:0]  out_cr,
  output logic [USER_W-1:0] out_user,
  output logic              busy
);
  localparam int CW = FRAC_W + 2;

  logic              v1, v2;
  logic              load1, load2, load3;
  mode_e             mode0, mode1, mode2;
  logic [USER_W-1:0] user1, user2;
  logic [PIX_W-1:0]  res [3];

  assign load3    = !out_valid || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;
  assign busy     = v1 || v2 || out_valid;
  assign mode0    = mode_e'(in_mode);

  // Valid flags and the mode/user sideband pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      mode1     <= MODE_JFIF;
      mode2     <= MODE_JFIF;
      user1     <= '0;
      user2     <= '0;
      out_user  <= '0;
    end else begin
      if (load1) begin
        v1 <= in_valid;
        if (in_valid) begin
          mode1 <= mode0;
          user1 <= in_user;
        end
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          mode2 <= mode1;
          user2 <= user1;
        end
      end
      if (load3) begin
        out_valid <= v2;
        if (v2) begin
          out_user <= user2;
        end
      end
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    localparam logic signed [CW-1:0] J0 = CW'(coef_scaled(MODE_JFIF, ch, 0, FRAC_W));
    localparam logic signed [CW-1:0] J1 = CW'(coef_scaled(MODE_JFIF, ch, 1, FRAC_W));
    localparam logic signed [CW-1:0] J2 = CW'(coef_scaled(MODE_JFIF, ch, 2, FRAC_W));
    localparam logic signed [CW-1:0] S0 = CW'(coef_scaled(MODE_STUDIO, ch, 0, FRAC_W));
    localparam logic signed [CW-1:0] S1 = CW'(coef_scaled(MODE_STUDIO, ch, 1, FRAC_W));
    localparam logic signed [CW-1:0] S2 = CW'(coef_scaled(MODE_STUDIO, ch, 2, FRAC_W));
    localparam logic [PIX_W-1:0] J_OFF = PIX_W'(offset_scaled(MODE_JFIF, ch, PIX_W));
    localparam logic [PIX_W-1:0] S_OFF = PIX_W'(offset_scaled(MODE_STUDIO, ch, PIX_W));
    localparam logic [PIX_W-1:0] J_LO  = PIX_W'(clamp_lo(MODE_JFIF, PIX_W));
    localparam logic [PIX_W-1:0] S_LO  = PIX_W'(clamp_lo(MODE_STUDIO, PIX_W));
    localparam logic [PIX_W-1:0] J_HI  = PIX_W'(clamp_hi(MODE_JFIF, ch, PIX_W));
    localparam logic [PIX_W-1:0] S_HI  = PIX_W'(clamp_hi(MODE_STUDIO, ch, PIX_W));

    // Each stage picks its constants from the mode of the pixel it is loading.
    rgb2ycbcr_mac #(
      .PIX_W (PIX_W),
      .FRAC_W(FRAC_W)
    ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .en1   (load1 && in_valid),
      .en2   (load2 && v1),
      .en3   (load3 && v2),
      .r     (in_r),
      .g     (in_g),
      .b     (in_b),
      .c0    ((mode0 == MODE_STUDIO) ? S0 : J0),
      .c1    ((mode0 == MODE_STUDIO) ? S1 : J1),
      .c2    ((mode0 == MODE_STUDIO) ? S2 : J2),
      .off   ((mode1 == MODE_STUDIO) ? S_OFF : J_OFF),
      .lo    ((mode2 == MODE_STUDIO) ? S_LO : J_LO),
      .hi    ((mode2 == MODE_STUDIO) ? S_HI : J_HI),
      .result(res[ch])
    );
  end

  assign out_y  = res[0];
  assign out_cb = res[1];
  assign out_cr = res[2];

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
// tb_rgb2ycbcr_stream: directed self-checking bench for rgb2ycbcr_stream
// (PIX_W=8, FRAC_W=8, USER_W=2). Hand-computed single-pixel vectors check
// values and latency; streamed phases check ordering, sideband alignment,
// backpressure and reset against an integer reference model.
module tb_rgb2ycbcr_stream;
  localparam int PIX_W  = 8;
  localparam int FRAC_W = 8;
  localparam int USER_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_mode;
  logic [PIX_W-1:0]  in_r, in_g, in_b;
  logic [USER_W-1:0] in_user;
  logic              out_valid, out_ready;
  logic [PIX_W-1:0]  out_y, out_cb, out_cr;
  logic [USER_W-1:0] out_user;
  logic              busy;

  always #5 clk = ~clk;

  rgb2ycbcr_stream #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .USER_W(USER_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr), .out_user(out_user),
    .busy(busy)
  );

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [1:0] user;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          occ, pix_idx, pix_limit, pix_first, ready_mode, n_out, n_in, mark;
  logic        hold_prev;
  logic [26:0] prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] chan(input int c0, input int c1, input int c2, input int off,
                                      input int lo, input int hi,
                                      input int r, input int g, input int b);
    int acc, v;
    acc = c0 * r + c1 * g + c2 * b + off * 256 + 128;
    v = acc >>> 8;
    if (v < lo) v = lo;
    else if (v > hi) v = hi;
    return v[7:0];
  endfunction

  function automatic exp_t model(input logic mode, input logic [7:0] r8, input logic [7:0] g8,
                                 input logic [7:0] b8, input logic [1:0] u);
    exp_t e;
    int r, g, b;
    r = int'(r8); g = int'(g8); b = int'(b8);
    if (!mode) begin
      e.y  = chan(77, 150, 29, 0, 0, 255, r, g, b);
      e.cb = chan(-43, -85, 128, 128, 0, 255, r, g, b);
      e.cr = chan(128, -107, -21, 128, 0, 255, r, g, b);
    end else begin
      e.y  = chan(66, 129, 25, 16, 16, 235, r, g, b);
      e.cb = chan(-38, -74, 112, 128, 16, 240, r, g, b);
      e.cr = chan(112, -94, -18, 128, 16, 240, r, g, b);
    end
    e.user = u;
    return e;
  endfunction

  // Present the next generated pixel (if any) and the phase's out_ready.
  task automatic drive();
    if (pix_idx < pix_limit) begin
      in_valid = 1'b1;
      in_r     = 8'((pix_idx * 37 + 11) % 256);
      in_g     = 8'((pix_idx * 91 + 200) % 256);
      in_b     = 8'((pix_idx * 53 + 7) % 256);
      in_mode  = pix_idx[0];
      in_user  = {pix_idx == pix_first, pix_idx == pix_limit - 1};
    end else begin
      in_valid = 1'b0;
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  // One streamed cycle: sample at negedge, score, advance, drive next inputs.
  task automatic tick();
    logic acc_in, acc_out;
    exp_t e;
    @(negedge clk);
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    check("in_ready_vs_fill", 32'(in_ready), (occ == 3 && !out_ready) ? 32'd0 : 32'd1);
    if (hold_prev) check("hold_stable", 32'({out_valid, out_y, out_cb, out_cr, out_user}),
                         32'(prev_out));
    if (acc_out) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("stream_y", 32'(out_y), 32'(e.y));
        check("stream_cb", 32'(out_cb), 32'(e.cb));
        check("stream_cr", 32'(out_cr), 32'(e.cr));
        check("stream_user", 32'(out_user), 32'(e.user));
        n_out++;
      end
    end
    if (acc_in) begin
      sb.push_back(model(in_mode, in_r, in_g, in_b, in_user));
      pix_idx++;
      n_in++;
    end
    occ       = occ + int'(acc_in) - int'(acc_out);
    hold_prev = out_valid && !out_ready;
    prev_out  = {out_valid, out_y, out_cb, out_cr, out_user};
    @(posedge clk);
    #1;
    drive();
  endtask

  // Single pixel with out_ready=1: out_valid must rise on the third edge.
  task automatic single(input string tag, input logic mode, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr);
    in_valid = 1'b1; in_mode = mode; in_r = r; in_g = g; in_b = b; in_user = 2'b01;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_lat3"}, 32'(out_valid), 32'd1);
    check({tag, "_y"}, 32'(out_y), 32'(ey));
    check({tag, "_cb"}, 32'(out_cb), 32'(ecb));
    check({tag, "_cr"}, 32'(out_cr), 32'(ecr));
    check({tag, "_user"}, 32'(out_user), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_r = '0; in_g = '0; in_b = '0;
    in_user = '0; out_ready = 1'b1;
    occ = 0; n_out = 0; n_in = 0; hold_prev = 1'b0; prev_out = '0;
    pix_idx = 0; pix_limit = 0; pix_first = 0; ready_mode = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'({out_y, out_cb, out_cr, out_user}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed single pixels
    single("jfif_grey", 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    single("jfif_red", 1'b0, 8'd255, 8'd0, 8'd0, 8'd77, 8'd85, 8'd255);
    single("jfif_white", 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128);
    single("std_black", 1'b1, 8'd0, 8'd0, 8'd0, 8'd16, 8'd128, 8'd128);
    single("std_white", 1'b1, 8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128);
    single("std_grey", 1'b1, 8'd128, 8'd128, 8'd128, 8'd126, 8'd128, 8'd128);

    // 16-pixel stream, alternating mode, random backpressure
    pix_first = 0; pix_idx = 0; pix_limit = 16; ready_mode = 1;
    n_out = 0; n_in = 0; occ = 0; hold_prev = 1'b0; sb.delete();
    drive();
    for (int c = 0; c < 400 && !(pix_idx == 16 && sb.size() == 0); c++) tick();
    check("stream_out_count", 32'(n_out), 32'd16);
    check("stream_left", 32'(sb.size()), 32'd0);

    // Stall for 10 cycles during a continuous stream
    pix_first = 100; pix_idx = 100; pix_limit = 140; ready_mode = 0;
    n_out = 0; n_in = 0;
    drive();
    repeat (4) tick();
    ready_mode = 2; out_ready = 1'b0;
    mark = n_out;
    repeat (10) tick();
    check("stall_no_out", 32'(n_out - mark), 32'd0);
    check("stall_held", 32'(n_in - n_out), 32'd3);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 0; out_ready = 1'b1;
    mark = n_in;
    repeat (6) tick();
    check("resume_rate", 32'(n_in - mark), 32'd6);
    pix_limit = pix_idx + 1;
    for (int c = 0; c < 50 && !(pix_idx >= pix_limit && sb.size() == 0); c++) tick();
    check("stall_drain", 32'(sb.size()), 32'd0);

    // Reset with 3 pixels in flight
    pix_first = 200; pix_idx = 200; pix_limit = 203; ready_mode = 2;
    drive();
    repeat (5) tick();
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete(); occ = 0; hold_prev = 1'b0;
    @(posedge clk); #1;
    single("post_rst", 1'b0, 8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_stream.md
Name: rgb2ycbcr_stream

Overview:
Pipelined, parameterised RGB-to-YCbCr colour-space converter. It accepts one pixel per clock over a valid/ready stream with full backpressure. It supports two conversion modes, selectable per pixel: JFIF full-range and BT.601 studio-range. It sits between the pixel source (line buffer / DMA reader) and the downsampling/DCT front end of the JPEG pipeline, replacing the single-shot start/done converter.

Parameters:
PIX_W, 8, bits per colour component in and out (8..12)
FRAC_W, 8, fractional bits of fixed-point coefficients (8..14)
USER_W, 2, sideband bits passed through with each pixel (e.g. {sof, eol})

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept input this cycle
in_mode  in  1  0 = JFIF full range, 1 = BT.601 studio range; sampled with pixel
in_r  in  PIX_W  red
in_g  in  PIX_W  green
in_b  in  PIX_W  blue
in_user  in  USER_W  sideband, delayed alongside pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts
out_y  out  PIX_W  luma
out_cb  out  PIX_W  blue-difference chroma
out_cr  out  PIX_W  red-difference chroma
out_user  out  USER_W  sideband matching this pixel
busy  out  1  any pipeline stage holds a valid pixel

Behaviour:
- Reset: all stage valid flags, out_valid and busy go to 0 at the first rising edge with rst=1. out_y/out_cb/out_cr/out_user reset to 0. A reset mid-stream discards all in-flight pixels. in_ready reads 1 in the cycle after reset deasserts.
- Handshake: a transfer occurs on an edge where valid && ready. Outputs hold stable while out_valid=1 and out_ready=0. in_ready must not depend on in_valid.
- Pipeline: 3 stages, bubble-collapsing:
  - S1 registers the nine products.
  - S2 registers the three sums, including offset and rounding constant.
  - S3 registers the clamped outputs (the out_* registers).
  - Stage k loads when it is empty or stage k+1 loads this cycle. S3 loads when !out_valid || out_ready. in_ready = S1 load condition.
- Latency and throughput: 3 cycles from input transfer to out_valid with out_ready held high. Sustained throughput is 1 pixel/clock.
- Arithmetic: for each channel, acc = c0*R + c1*G + c2*B + (OFF << FRAC_W) + 2^(FRAC_W-1).
  - Result = acc >>> FRAC_W (arithmetic shift), then clamp to the mode range.
  - Signed accumulator width = PIX_W + FRAC_W + 3. No intermediate truncation.
- Coefficients: each is round(real*2^FRAC_W) and scales with FRAC_W.
  - At FRAC_W=8, JFIF: Y {77,150,29}, Cb {-43,-85,128}, Cr {128,-107,-21}.
  - At FRAC_W=8, studio: Y {66,129,25}, Cb {-38,-74,112}, Cr {112,-94,-18}.
- Offsets are scaled by 2^(PIX_W-8):
  - JFIF: Y 0, C 128.
  - Studio: Y 16, C 128.
- Clamp ranges, scaled by 2^(PIX_W-8):
  - JFIF: [0, 2^PIX_W-1].
  - Studio: Y [16,235], C [16,240].
- Mode and user bits travel with their own pixel. Changing in_mode between consecutive pixels is legal with no bubble.
- Stall with out_ready=0: the pipeline fills to 3 pixels, then in_ready=0. No pixel is lost or duplicated.
- busy = OR of the three stage valid flags.

Decomposition:
- Package rgb2ycbcr_pkg:
  - mode encodings MODE_JFIF / MODE_STUDIO;
  - real-valued coefficient table and offset/clamp constants at 8-bit scale;
  - functions producing scaled coefficients for given PIX_W and FRAC_W.
- Sub-module rgb2ycbcr_mac, instantiated three times (Y, Cb, Cr):
  - inputs: coefficient triple, offset, clamp bounds;
  - performs the stage-1 products, stage-2 sum/round, stage-3 clamp;
  - stall enables are driven by the top level.

Test Plan (PIX_W=8, FRAC_W=8, USER_W=2):
- JFIF, RGB (128,128,128), out_ready=1 -> Y=128, Cb=128, Cr=128, out_valid exactly 3 cycles after the input transfer.
- JFIF, RGB (255,0,0) -> Y=77, Cb=85, Cr=255 (raw 256 clamps to 255); then (255,255,255) -> Y=255, Cb=128, Cr=128.
- Studio, RGB (0,0,0) -> Y=16, Cb=128, Cr=128; (255,255,255) -> Y=235, Cb=128, Cr=128; (128,128,128) -> Y=126, Cb=128, Cr=128.
- Back-to-back stream of 16 pixels alternating in_mode, user={sof,eol} with sof on the first and eol on the last; out_ready random 50%. Required: outputs match the per-pixel reference model in order, user bits stay aligned, no drop or duplicate, in_ready=0 only while the pipeline is full.
- out_ready=0 for 10 cycles during a continuous stream -> exactly 3 pixels captured, in_ready=0, outputs stable. On release, resumes at 1 pixel/clock.
- Assert rst for 1 cycle with 3 pixels in flight -> out_valid=0, busy=0 next cycle. The next accepted pixel emerges after 3 cycles with the correct value.
